// File: rtl/majority_pkg.sv
// majority_pkg: shared types and constants for the majority-vote round controller
// and the combinational majority block.
//   state_t       - round controller state encoding
//   tally_width() - bits needed to hold a tally of 0..n votes
//   DEFAULT_N / DEFAULT_MAJORITY - default round size and yes threshold
package majority_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N        = 5;
    localparam int unsigned DEFAULT_MAJORITY = 3;

    // Width of an unsigned counter able to hold the values 0..n.
    function automatic int unsigned tally_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/majority_idle_timer.sv
// majority_idle_timer: loadable down-counter that measures idle cycles between
// accepted votes.
//   clk, rst_n - clock and synchronous active-low reset
//   load       - reload the counter with TIMEOUT (round start or vote accept)
//   dec        - count one idle cycle
//   expire_c   - counter has run down to zero (combinational from the count)
module majority_idle_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expire_c
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(TIMEOUT);
        end else if (dec && (count != '0)) begin
            count <= count - TW'(1);
        end
    end

    assign expire_c = (count == '0);

endmodule

// File: rtl/majority_round_ctrl.sv
// majority_round_ctrl: runs one streamed majority-vote round over N votes,
// ending early as soon as the outcome is decided, or on idle timeout.
//   clk, rst_n           - clock and synchronous active-low reset
//   start                - begin a round (IDLE only)
//   abort                - cancel the round (COLLECT only), no done pulse
//   vote_valid, vote_bit - vote handshake input, 1 = yes
//   vote_ready           - vote accepted this cycle (decoded from state)
//   busy                 - round in progress (COLLECT or DONE)
//   done                 - one-cycle pulse, y/timed_out/tallies are final
//   y                    - round decision
//   timed_out            - round ended by idle timeout
//   yes_count, no_count  - tallies of the last or current round
module majority_round_ctrl
    import majority_pkg::*;
#(
    parameter  int unsigned N        = DEFAULT_N,
    parameter  int unsigned MAJORITY = DEFAULT_MAJORITY,
    parameter  int unsigned TIMEOUT  = 16,
    localparam int unsigned CW       = tally_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          vote_valid,
    input  logic          vote_bit,
    output logic          vote_ready,
    output logic          busy,
    output logic          done,
    output logic          y,
    output logic          timed_out,
    output logic [CW-1:0] yes_count,
    output logic [CW-1:0] no_count
);

    localparam logic [CW-1:0] YES_LIMIT = CW'(MAJORITY);
    localparam logic [CW-1:0] NO_LIMIT  = CW'(N - MAJORITY);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] yes_d;
    logic [CW-1:0] no_d;
    logic [CW-1:0] yes_inc;
    logic [CW-1:0] no_inc;
    logic          y_d;
    logic          timed_out_d;
    logic          accept;
    logic          expire;
    logic          timer_load;
    logic          timer_dec;

    assign vote_ready = (state_q == COLLECT);
    assign accept     = vote_valid && vote_ready;
    assign yes_inc    = yes_count + CW'(vote_bit);
    assign no_inc     = no_count + CW'(!vote_bit);

    // Reload on round start and on every accepted vote; count idle COLLECT cycles.
    assign timer_load = ((state_q == IDLE) && start) || accept;
    assign timer_dec  = (state_q == COLLECT) && !accept;

    majority_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dec      (timer_dec),
        .expire_c (expire)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        yes_d       = yes_count;
        no_d        = no_count;
        y_d         = y;
        timed_out_d = timed_out;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    yes_d       = '0;
                    no_d        = '0;
                    y_d         = 1'b0;
                    timed_out_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                // Priority: abort, then vote accept, then timeout.
                if (abort) begin
                    y_d     = 1'b0;
                    state_d = IDLE;
                end else if (accept) begin
                    yes_d = yes_inc;
                    no_d  = no_inc;
                    if (yes_inc >= YES_LIMIT) begin
                        y_d     = 1'b1;
                        state_d = DONE;
                    end else if (no_inc > NO_LIMIT) begin
                        y_d     = 1'b0;
                        state_d = DONE;
                    end
                end else if (expire) begin
                    y_d         = 1'b0;
                    timed_out_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; done/busy are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            yes_count <= '0;
            no_count  <= '0;
            y         <= 1'b0;
            timed_out <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            yes_count <= yes_d;
            no_count  <= no_d;
            y         <= y_d;
            timed_out <= timed_out_d;
            done      <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_majority_round_ctrl.sv
// tb_majority_round_ctrl: directed self-checking bench for majority_round_ctrl
// with N=5, MAJORITY=3, TIMEOUT=16.
module tb_majority_round_ctrl;

    localparam int unsigned N        = 5;
    localparam int unsigned MAJORITY = 3;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned CW       = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          vote_valid;
    logic          vote_bit;
    logic          vote_ready;
    logic          busy;
    logic          done;
    logic          y;
    logic          timed_out;
    logic [CW-1:0] yes_count;
    logic [CW-1:0] no_count;

    int checks   = 0;
    int failures = 0;

    majority_round_ctrl #(
        .N        (N),
        .MAJORITY (MAJORITY),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .vote_valid (vote_valid),
        .vote_bit   (vote_bit),
        .vote_ready (vote_ready),
        .busy       (busy),
        .done       (done),
        .y          (y),
        .timed_out  (timed_out),
        .yes_count  (yes_count),
        .no_count   (no_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full observable status: {vote_ready, busy, done, y, timed_out, yes, no}.
    task automatic chk_all(input string tag, input logic rdy, input logic bsy, input logic dn,
                           input logic yy, input logic to, input int unsigned yes,
                           input int unsigned no);
        chk({tag, ".vote_ready"}, 32'(vote_ready), 32'(rdy));
        chk({tag, ".busy"},       32'(busy),       32'(bsy));
        chk({tag, ".done"},       32'(done),       32'(dn));
        chk({tag, ".y"},          32'(y),          32'(yy));
        chk({tag, ".timed_out"},  32'(timed_out),  32'(to));
        chk({tag, ".yes"},        32'(yes_count),  yes);
        chk({tag, ".no"},         32'(no_count),   no);
    endtask

    task automatic vote(input logic b);
        vote_valid = 1'b1;
        vote_bit   = b;
        tick();
        vote_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        vote_valid = 1'b0;
        vote_bit   = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Round 1: votes 1,0,1,1 decide yes on the 4th accept; vote offered in IDLE ignored.
        start      = 1'b1;
        vote_valid = 1'b1;
        vote_bit   = 1'b1;
        tick();
        start = 1'b0;
        vote_valid = 1'b0;
        chk_all("r1_start", 1, 1, 0, 0, 0, 0, 0);
        vote(1'b1);
        vote(1'b0);
        chk_all("r1_v2", 1, 1, 0, 0, 0, 1, 1);
        start = 1'b1;                           // start in COLLECT is ignored
        vote(1'b1);
        start = 1'b0;
        chk_all("r1_v3", 1, 1, 0, 0, 0, 2, 1);
        vote(1'b1);
        chk_all("r1_done", 0, 1, 1, 1, 0, 3, 1);
        // A 5th vote and a start offered during DONE must both be ignored.
        vote_valid = 1'b1;
        vote_bit   = 1'b1;
        start      = 1'b1;
        tick();
        vote_valid = 1'b0;
        chk_all("r1_idle", 0, 0, 0, 1, 0, 3, 1);

        // Round 2: back-to-back start in first IDLE cycle; votes 0,0,1,0 decide no.
        tick();
        start = 1'b0;
        chk_all("r2_start", 1, 1, 0, 0, 0, 0, 0);
        vote(1'b0);
        vote(1'b0);
        vote(1'b1);
        chk_all("r2_v3", 1, 1, 0, 0, 0, 1, 2);
        vote(1'b0);
        chk_all("r2_done", 0, 1, 1, 0, 0, 1, 3);
        tick();
        chk_all("r2_idle", 0, 0, 0, 0, 0, 1, 3);

        // Round 3: one yes vote then silence; done TIMEOUT+1 edges after the accept.
        start = 1'b1;
        tick();
        start = 1'b0;
        vote(1'b1);
        for (int i = 0; i < int'(TIMEOUT); i++) tick();
        chk_all("r3_pre_to", 1, 1, 0, 0, 0, 1, 0);
        tick();
        chk_all("r3_timeout", 0, 1, 1, 0, 1, 1, 0);
        tick();
        chk_all("r3_idle", 0, 0, 0, 0, 1, 1, 0);

        // Round 4: vote in the cycle the timer expires wins; then abort with a deciding vote.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("r4_start", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(TIMEOUT); i++) tick();
        vote(1'b0);
        chk_all("r4_vote_beats_to", 1, 1, 0, 0, 0, 0, 1);
        vote(1'b1);
        vote(1'b1);
        chk_all("r4_pre_abort", 1, 1, 0, 0, 0, 2, 1);
        abort = 1'b1;
        vote(1'b1);                             // would decide yes, but abort wins
        abort = 1'b0;
        chk_all("r4_abort", 0, 0, 0, 0, 0, 2, 1);
        tick();
        chk_all("r4_abort_hold", 0, 0, 0, 0, 0, 2, 1);

        // Round 5: reset after two votes, then a clean round.
        start = 1'b1;
        tick();
        start = 1'b0;
        vote(1'b1);
        vote(1'b0);
        chk_all("r5_mid", 1, 1, 0, 0, 0, 1, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all("r5_reset", 0, 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        vote(1'b1);
        vote(1'b1);
        vote(1'b1);
        chk_all("r5_done", 0, 1, 1, 1, 0, 3, 0);
        tick();
        chk_all("r5_idle", 0, 0, 0, 1, 0, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/majority_round_ctrl.md
# majority_round_ctrl

Sequential controller that runs one majority-vote round over N serially presented votes. It accepts votes through a valid/ready handshake, keeps running yes/no tallies, and ends the round as soon as the outcome is mathematically decided. It then reports the decision with a one-cycle done pulse. The block sits in front of the voter datapath and turns the combinational N-bit majority into a streamed, abortable, time-bounded round.

## Interface

Parameters:
- N, 5, votes per round (1..255)
- MAJORITY, 3, yes votes required for y=1 (1..N)
- TIMEOUT, 16, max idle cycles between accepted votes (≥1)
- CW, $clog2(N+1), tally width (derived, localparam)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a round; honoured only in IDLE
- abort  in  1  cancel the current round; honoured only in COLLECT
- vote_valid  in  1  vote_bit is valid this cycle
- vote_bit  in  1  1 = yes, 0 = no
- vote_ready  out  1  controller accepts a vote this cycle
- busy  out  1  high in COLLECT and DONE
- done  out  1  one-cycle pulse, round result is valid
- y  out  1  round decision
- timed_out  out  1  round ended by timeout
- yes_count  out  CW  yes votes accepted in the last or current round
- no_count  out  CW  no votes accepted in the last or current round

## Operation

- States: IDLE, COLLECT, DONE.
- Reset (rst_n=0 at a clock edge): state=IDLE; all outputs 0; tallies 0; idle timer 0.
- IDLE:
  - start=1 → clear yes_count, no_count, y, timed_out and the idle timer; go to COLLECT.
  - vote_valid is ignored.
- COLLECT:
  - vote_ready=1.
  - Vote accepted when vote_valid & vote_ready; yes_count or no_count increments.
  - Early decision on the accepting edge:
    - Updated yes_count ≥ MAJORITY → y=1, go to DONE.
    - Updated no_count > N−MAJORITY → y=0, go to DONE.
    - Both conditions evaluate on the updated tallies in the same cycle.
  - Because the round ends as soon as the outcome is decided, at most N votes are ever accepted.
  - Idle timer:
    - Counts cycles in COLLECT without an accepted vote; resets on each accept.
    - Reaching TIMEOUT → y=0, timed_out=1, go to DONE.
    - A vote accepted in the same cycle the timer would expire wins; no timeout that cycle.
  - abort=1 → go to IDLE; no done pulse; tallies hold their partial values; y=0.
  - abort has priority over a simultaneous vote accept and over timeout.
- DONE:
  - done=1 for exactly this cycle; vote_ready=0.
  - Next state is IDLE unconditionally; start in DONE is ignored.
- y, timed_out, yes_count and no_count hold after DONE until the next accepted start or reset.
- Tally arithmetic is unsigned CW-bit and cannot overflow, because the round ends before N+1 votes.

## Timing

- start sampled at edge k → vote_ready=1 from cycle k+1.
- Deciding vote accepted at edge m → done=1, y valid, vote_ready=0 in cycle m+1; IDLE in cycle m+2.
- Minimum round length: start, MAJORITY consecutive yes votes, then DONE, for a total of MAJORITY+2 cycles start-to-IDLE.
- Back-to-back rounds: start may be asserted in the cycle after DONE (first IDLE cycle).
- Timeout: with no accepted votes after entering COLLECT, done asserts TIMEOUT+1 cycles after entry.
- rst_n low in any state, including mid-round → IDLE next cycle, no done pulse.
- All outputs are registered; no combinational input-to-output paths except vote_ready, which is decoded from state only.

## Structure

- Shared package majority_pkg holds:
  - state enum (IDLE, COLLECT, DONE);
  - function tally_width(N) returning $clog2(N+1);
  - default N/MAJORITY constants shared with the combinational majority block.
- One natural sub-module: majority_idle_timer, a loadable down-counter with clear-on-accept and an expire flag, width $clog2(TIMEOUT+1).
- FSM and tallies live in the top module.

## Test plan

- N=5, MAJ=3, start then votes 1,0,1,1 back-to-back → done 1 cycle after 4th accept, y=1, yes=3, no=1; the 5th vote is never accepted (vote_ready=0).
- Votes 0,0,1,0 → decision on 4th accept (no=3 > 2), y=0, yes=1, no=3, timed_out=0.
- start, one yes vote, then vote_valid held low → done exactly TIMEOUT+1 cycles after the last accept, y=0, timed_out=1, yes=1.
- abort asserted together with a deciding vote → IDLE next cycle, no done pulse, tallies at their pre-abort values.
- rst_n low during COLLECT after 2 votes → all outputs 0 next cycle; a fresh start runs a clean round.
- start asserted in COLLECT and in DONE → ignored, no tally clear; start in the cycle after DONE → new round begins with tallies 0.
